// File: rtl/mod10_seq_checker_if.sv
// Bus between a mod-10 counter monitor and whoever drives/observes it.
// The master side supplies samples and the clear; the slave side is the checker.
interface mod10_seq_checker_if #(
   parameter int WRAP_W = 8,
   parameter int ERR_W  = 8
);
   logic              en;
   logic [3:0]        q_in;
   logic              err_clr;
   logic              locked;
   logic [3:0]        expected;
   logic              err_pulse;
   logic              illegal_pulse;
   logic              err_sticky;
   logic [ERR_W-1:0]  err_count;
   logic [WRAP_W-1:0] wrap_count;

   modport master (
      output en, q_in, err_clr,
      input  locked, expected, err_pulse, illegal_pulse, err_sticky, err_count, wrap_count
   );

   modport slave (
      input  en, q_in, err_clr,
      output locked, expected, err_pulse, illegal_pulse, err_sticky, err_count, wrap_count
   );
endinterface

// File: rtl/mod10_seq_checker.sv
// Receive-side monitor for a 4-bit mod-10 counter bus. Locks onto the 0..9
// sequence after LOCK_CNT consecutive good samples, then flags mismatches,
// illegal codes (>9) and counts completed decades. All outputs are registered.
module mod10_seq_checker #(
   parameter int LOCK_CNT = 3,
   parameter int WRAP_W   = 8,
   parameter int ERR_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   mod10_seq_checker_if.slave  bus
);
   localparam int GC_W = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

   state_t            state_q, state_d;
   logic [3:0]        exp_q, exp_d;
   logic [GC_W-1:0]   good_q, good_d;
   logic              locked_q, locked_d;
   logic              errp_q, errp_d;
   logic              illp_q, illp_d;
   logic              sticky_q, sticky_d;
   logic [ERR_W-1:0]  errc_q, errc_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;

   function automatic logic [3:0] next_mod10(input logic [3:0] v);
      return (v == 4'd9) ? 4'd0 : v + 4'd1;
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
      return (&v) ? v : v + WRAP_W'(1);
   endfunction

   // Next-state and output decode; a clear applies first so an error in the
   // same cycle counts from zero.
   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      good_d   = good_q;
      errp_d   = 1'b0;
      illp_d   = 1'b0;
      sticky_d = bus.err_clr ? 1'b0 : sticky_q;
      errc_d   = bus.err_clr ? '0 : errc_q;
      wrap_d   = wrap_q;
      if (bus.en) begin
         if (bus.q_in > 4'd9) begin
            illp_d  = 1'b1;
            state_d = IDLE;
            good_d  = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  exp_d   = next_mod10(bus.q_in);
                  good_d  = GC_W'(1);
                  state_d = SYNC;
               end
               SYNC: begin
                  exp_d = next_mod10(bus.q_in);
                  if (bus.q_in == exp_q) begin
                     good_d = good_q + GC_W'(1);
                     if (good_d == GC_W'(LOCK_CNT)) state_d = LOCKED;
                  end else begin
                     good_d = GC_W'(1);
                  end
               end
               LOCKED: begin
                  exp_d = next_mod10(bus.q_in);
                  if (bus.q_in == exp_q) begin
                     if (bus.q_in == 4'd0) wrap_d = sat_inc_wrap(wrap_q);
                  end else begin
                     errp_d   = 1'b1;
                     sticky_d = 1'b1;
                     errc_d   = sat_inc_err(errc_d);
                     good_d   = GC_W'(1);
                     state_d  = SYNC;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
      locked_d = (state_d == LOCKED);
   end

   // State and output registers, cleared immediately by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         exp_q    <= '0;
         good_q   <= '0;
         locked_q <= 1'b0;
         errp_q   <= 1'b0;
         illp_q   <= 1'b0;
         sticky_q <= 1'b0;
         errc_q   <= '0;
         wrap_q   <= '0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         good_q   <= good_d;
         locked_q <= locked_d;
         errp_q   <= errp_d;
         illp_q   <= illp_d;
         sticky_q <= sticky_d;
         errc_q   <= errc_d;
         wrap_q   <= wrap_d;
      end
   end

   assign bus.locked        = locked_q;
   assign bus.expected      = exp_q;
   assign bus.err_pulse     = errp_q;
   assign bus.illegal_pulse = illp_q;
   assign bus.err_sticky    = sticky_q;
   assign bus.err_count     = errc_q;
   assign bus.wrap_count    = wrap_q;
endmodule

// File: tb/tb_mod10_seq_checker.sv
// Directed bench for mod10_seq_checker: a vector table for the main flow,
// then hand-written sequences for decades, saturation and async reset.
module tb_mod10_seq_checker;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mod10_seq_checker_if #(.WRAP_W(8), .ERR_W(8)) bus_a ();
   mod10_seq_checker_if #(.WRAP_W(2), .ERR_W(8)) bus_b ();

   mod10_seq_checker #(.LOCK_CNT(3), .WRAP_W(8), .ERR_W(8)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );
   mod10_seq_checker #(.LOCK_CNT(3), .WRAP_W(2), .ERR_W(8)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   typedef struct {
      bit         en;
      logic [3:0] q;
      bit         clr;
      bit         locked;
      logic [3:0] expv;
      bit         errp;
      bit         illp;
      bit         sticky;
      int         errc;
      int         wrapc;
   } vec_t;

   vec_t vq[$];

   task automatic add(input bit e, input logic [3:0] q, input bit c, input bit l,
                      input logic [3:0] x, input bit ep, input bit ip, input bit st,
                      input int ec, input int wc);
      vec_t v;
      v.en = e; v.q = q; v.clr = c; v.locked = l; v.expv = x;
      v.errp = ep; v.illp = ip; v.sticky = st; v.errc = ec; v.wrapc = wc;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, want);
      end
   endtask

   task automatic apply(input bit e, input logic [3:0] q, input bit c);
      @(negedge clk);
      bus_a.en = e; bus_a.q_in = q; bus_a.err_clr = c;
      bus_b.en = e; bus_b.q_in = q; bus_b.err_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".locked"},   32'(bus_a.locked), 0);
      chk({tag, ".expected"}, 32'(bus_a.expected), 0);
      chk({tag, ".err_pulse"}, 32'(bus_a.err_pulse), 0);
      chk({tag, ".illegal"},  32'(bus_a.illegal_pulse), 0);
      chk({tag, ".sticky"},   32'(bus_a.err_sticky), 0);
      chk({tag, ".err_count"}, 32'(bus_a.err_count), 0);
      chk({tag, ".wrap_count"}, 32'(bus_a.wrap_count), 0);
      chk({tag, ".b_wrap"},   32'(bus_b.wrap_count), 0);
   endtask

   task automatic pulse_reset_between_edges();
      @(negedge clk);
      #2 reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      bus_a.en = 0; bus_a.q_in = 0; bus_a.err_clr = 0;
      bus_b.en = 0; bus_b.q_in = 0; bus_b.err_clr = 0;

      //    en q  clr | lock exp ep ip st ec wc
      add(1, 0,  0,   0, 1, 0, 0, 0, 0, 0);
      add(1, 1,  0,   0, 2, 0, 0, 0, 0, 0);
      add(1, 2,  0,   1, 3, 0, 0, 0, 0, 0);
      add(1, 3,  0,   1, 4, 0, 0, 0, 0, 0);
      add(1, 4,  0,   1, 5, 0, 0, 0, 0, 0);
      add(1, 5,  0,   1, 6, 0, 0, 0, 0, 0);
      add(1, 6,  0,   1, 7, 0, 0, 0, 0, 0);
      add(1, 7,  0,   1, 8, 0, 0, 0, 0, 0);
      add(1, 8,  0,   1, 9, 0, 0, 0, 0, 0);
      add(1, 9,  0,   1, 0, 0, 0, 0, 0, 0);
      add(1, 0,  0,   1, 1, 0, 0, 0, 0, 1);
      add(1, 1,  0,   1, 2, 0, 0, 0, 0, 1);
      add(0, 15, 0,   1, 2, 0, 0, 0, 0, 1);
      add(1, 5,  0,   0, 6, 1, 0, 1, 1, 1);
      add(1, 6,  0,   0, 7, 0, 0, 1, 1, 1);
      add(1, 7,  0,   1, 8, 0, 0, 1, 1, 1);
      add(1, 12, 0,   0, 8, 0, 1, 1, 1, 1);
      add(1, 4,  0,   0, 5, 0, 0, 1, 1, 1);
      add(1, 5,  0,   0, 6, 0, 0, 1, 1, 1);
      add(1, 6,  0,   1, 7, 0, 0, 1, 1, 1);
      add(1, 7,  1,   1, 8, 0, 0, 0, 0, 1);
      add(1, 8,  0,   1, 9, 0, 0, 0, 0, 1);
      add(1, 3,  1,   0, 4, 1, 0, 1, 1, 1);
      add(1, 4,  0,   0, 5, 0, 0, 1, 1, 1);
      add(1, 5,  0,   1, 6, 0, 0, 1, 1, 1);
      add(0, 9,  1,   1, 6, 0, 0, 0, 0, 1);
      add(1, 6,  0,   1, 7, 0, 0, 0, 0, 1);
      add(1, 6,  0,   0, 7, 1, 0, 1, 1, 1);
      add(1, 7,  0,   0, 8, 0, 0, 1, 1, 1);
      add(1, 8,  0,   1, 9, 0, 0, 1, 1, 1);
      add(1, 9,  0,   1, 0, 0, 0, 1, 1, 1);
      add(1, 0,  0,   1, 1, 0, 0, 1, 1, 2);

      #12;
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         apply(vq[i].en, vq[i].q, vq[i].clr);
         chk($sformatf("v%0d.locked", i),   32'(bus_a.locked),        32'(vq[i].locked));
         chk($sformatf("v%0d.expected", i), 32'(bus_a.expected),      32'(vq[i].expv));
         chk($sformatf("v%0d.err_pulse", i), 32'(bus_a.err_pulse),    32'(vq[i].errp));
         chk($sformatf("v%0d.illegal", i),  32'(bus_a.illegal_pulse), 32'(vq[i].illp));
         chk($sformatf("v%0d.sticky", i),   32'(bus_a.err_sticky),    32'(vq[i].sticky));
         chk($sformatf("v%0d.err_count", i), 32'(bus_a.err_count),    vq[i].errc);
         chk($sformatf("v%0d.wrap_count", i), 32'(bus_a.wrap_count),  vq[i].wrapc);
      end

      // Two more decades from a locked position expecting 1.
      for (int i = 0; i < 20; i++) begin
         apply(1, 4'((i + 1) % 10), 0);
         chk($sformatf("dec%0d.err_pulse", i), 32'(bus_a.err_pulse), 0);
      end
      chk("dec.wrap_count", 32'(bus_a.wrap_count), 4);
      chk("dec.expected",   32'(bus_a.expected), 1);
      chk("dec.locked",     32'(bus_a.locked), 1);
      chk("dec.err_count",  32'(bus_a.err_count), 1);

      // Fresh start, five decades: 2-bit wrap counter must stick at 3.
      pulse_reset_between_edges();
      #1 reset = 1'b0;
      for (int i = 0; i <= 50; i++) apply(1, 4'(i % 10), 0);
      chk("sat.a_wrap",   32'(bus_a.wrap_count), 5);
      chk("sat.b_wrap",   32'(bus_b.wrap_count), 3);
      chk("sat.b_locked", 32'(bus_b.locked), 1);
      chk("sat.err_count", 32'(bus_a.err_count), 0);

      // Reset mid-decade between edges, then relock needs three samples.
      apply(1, 1, 0);
      apply(1, 2, 0);
      apply(1, 3, 0);
      chk("pre_rst.expected", 32'(bus_a.expected), 4);
      pulse_reset_between_edges();
      #1;
      chk_all_zero("async_rst");
      #1 reset = 1'b0;
      apply(1, 5, 0);
      chk("relock1.locked", 32'(bus_a.locked), 0);
      apply(1, 6, 0);
      chk("relock2.locked", 32'(bus_a.locked), 0);
      apply(1, 7, 0);
      chk("relock3.locked",   32'(bus_a.locked), 1);
      chk("relock3.expected", 32'(bus_a.expected), 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mod10_seq_checker.md
Name: mod10_seq_checker

Overview:
Receive-side monitor for the 4-bit mod-10 counter output bus. It samples the counter value, locks onto the 0..9 sequence, and flags skipped, repeated or illegal codes. It also counts completed decades (9→0 wraps) and errors. It sits next to any mod-10 counter instance, in RTL or in bench harnesses, as a synthesizable self-check.

Parameters:
LOCK_CNT, 3, consecutive correctly-incrementing samples needed to declare lock (min 2)
WRAP_W, 8, width of the saturating wrap counter
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
en  input  1  sample qualifier; q_in is evaluated only on cycles with en=1
q_in  input  4  counter value under check
err_clr  input  1  synchronous clear of err_sticky and err_count
locked  output  1  high while in LOCKED state
expected  output  4  next value the checker expects (0..9)
err_pulse  output  1  one-cycle pulse on a sequence mismatch while locked
illegal_pulse  output  1  one-cycle pulse when a sampled q_in is greater than 9
err_sticky  output  1  set on any err_pulse; held until err_clr or reset
err_count  output  ERR_W  saturating count of err_pulse events
wrap_count  output  WRAP_W  saturating count of accepted 9→0 transitions while locked

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs are 0: locked, expected, both pulses, err_sticky, err_count and wrap_count. Internal good_cnt is also 0.
- All outputs are registered. The effect of a sample appears on the clock edge that samples it, so it is visible in the following cycle.
- en=0: no state change, and pulses are 0. err_clr still acts.
- The pulse outputs are 0 on every cycle that has no qualifying event.
- Illegal code (q_in>9, en=1), in any state:
  - illegal_pulse=1.
  - Next state is IDLE; locked=0; good_cnt=0.
  - Not counted in err_count.
- States IDLE, SYNC, LOCKED. Transitions below assume en=1 and a legal q_in.
- IDLE:
  - expected ← (q_in+1) mod 10; good_cnt ← 1; next state SYNC.
- SYNC:
  - If q_in==expected: expected advances mod 10 and good_cnt increments. When good_cnt reaches LOCK_CNT, go to LOCKED.
  - If q_in≠expected: reseed with expected ← (q_in+1) mod 10 and good_cnt ← 1.
  - No error reporting in SYNC.
- LOCKED:
  - If q_in==expected: expected advances mod 10. If q_in==0, wrap_count increments, saturating at all-ones.
  - If q_in≠expected: err_pulse=1, err_sticky ← 1, err_count increments (saturating). Next state SYNC, reseeded from q_in as above; locked=0.
- Wrap: the expected value after 9 is 0. A 9→0 transition is an accepted match, not an error.
- err_clr and a new error in the same cycle: the error wins. Result is err_sticky=1 and err_count=1 (clear, then count).
- Counters and sticky are preserved across loss of lock; only err_clr or reset clears them.
- Reset mid-operation: all state is dropped immediately. Relock requires LOCK_CNT fresh samples.
- While the monitored counter is held in reset, drive en=0. A constant 0 stream would otherwise never lock, but it would not raise errors either.

Test Plan:
- Lock: reset, en=1, feed 0,1,2 → locked=1 the cycle after sample 2, expected=3; no pulses.
- Decade wrap: locked, feed 3..9 then 0 → wrap_count=1, expected=1, err_count=0. Run 20 more values → wrap_count=3.
- Skip error: locked at 3, feed 5 → err_pulse high exactly one cycle, err_count=1, err_sticky=1, locked=0, expected=6. Feed 6,7 → locked=1 again.
- Illegal code: locked, feed 12 → illegal_pulse one cycle, locked=0, err_count unchanged. Next legal value re-enters SYNC.
- Clear/en/saturation: assert err_clr together with a mismatch → err_count=1, err_sticky=1. Hold en=0 with garbage on q_in → no state change. With WRAP_W=2, run 5 decades → wrap_count=3.
- Async reset: assert reset mid-decade between clock edges → all outputs 0 before the next edge. Release reset → LOCK_CNT samples are needed to relock.
